// File: rtl/ex_mem_register_if.sv
// EX/MEM stage bundle: EX-side fields and pipeline controls in, registered MEM-side fields out.
// master drives the EX side and observes MEM; slave is the pipeline register itself.
interface ex_mem_register_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int CNT_WIDTH  = 16
);
  logic                  Stall;
  logic                  Flush;
  logic                  PCSrc;
  logic                  Valid_in;
  logic                  MemToReg_in;
  logic                  RegWrite_in;
  logic                  MemWrite_in;
  logic                  MemRead_in;
  logic                  Branch_in;
  logic                  Is_Zero_in;
  logic [DATA_WIDTH-1:0] ALU_Result_in;
  logic [DATA_WIDTH-1:0] WriteData_in;
  logic [DATA_WIDTH-1:0] PC_Branch_in;
  logic [REG_AW-1:0]     RegisterRd_in;

  logic                  Valid_out;
  logic                  MemToReg_out;
  logic                  RegWrite_out;
  logic                  MemWrite_out;
  logic                  MemRead_out;
  logic                  Branch_out;
  logic                  Is_Zero_out;
  logic [DATA_WIDTH-1:0] ALU_Result_out;
  logic [DATA_WIDTH-1:0] WriteData_out;
  logic [DATA_WIDTH-1:0] PC_Branch_out;
  logic [REG_AW-1:0]     RegisterRd_out;
  logic [CNT_WIDTH-1:0]  Bubble_Count;

  modport master (
    output Stall, Flush, PCSrc, Valid_in, MemToReg_in, RegWrite_in, MemWrite_in,
           MemRead_in, Branch_in, Is_Zero_in, ALU_Result_in, WriteData_in,
           PC_Branch_in, RegisterRd_in,
    input  Valid_out, MemToReg_out, RegWrite_out, MemWrite_out, MemRead_out,
           Branch_out, Is_Zero_out, ALU_Result_out, WriteData_out, PC_Branch_out,
           RegisterRd_out, Bubble_Count
  );

  modport slave (
    input  Stall, Flush, PCSrc, Valid_in, MemToReg_in, RegWrite_in, MemWrite_in,
           MemRead_in, Branch_in, Is_Zero_in, ALU_Result_in, WriteData_in,
           PC_Branch_in, RegisterRd_in,
    output Valid_out, MemToReg_out, RegWrite_out, MemWrite_out, MemRead_out,
           Branch_out, Is_Zero_out, ALU_Result_out, WriteData_out, PC_Branch_out,
           RegisterRd_out, Bubble_Count
  );
endinterface

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register, 1-cycle latency, all outputs registered.
// Stall holds contents; Flush or PCSrc loads a bubble and overrides Stall; saturating bubble count.
module ex_mem_register #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5,
  parameter int CNT_WIDTH  = 16
) (
  input logic          clock,
  input logic          reset_n,
  ex_mem_register_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  branch;
    logic                  is_zero;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] pc_branch;
    logic [REG_AW-1:0]     rd;
  } stage_t;

  stage_t               stage_q, stage_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cnt_sat;
  logic                 flush;

  assign flush   = bus.Flush | bus.PCSrc;
  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (flush) begin
      stage_d = '0;
      cnt_d   = cnt_sat;
    end else if (!bus.Stall) begin
      // Control bits are gated by Valid_in so an invalid entry has no side effects in MEM.
      stage_d.valid      = bus.Valid_in;
      stage_d.mem_to_reg = bus.MemToReg_in & bus.Valid_in;
      stage_d.reg_write  = bus.RegWrite_in & bus.Valid_in;
      stage_d.mem_write  = bus.MemWrite_in & bus.Valid_in;
      stage_d.mem_read   = bus.MemRead_in  & bus.Valid_in;
      stage_d.branch     = bus.Branch_in   & bus.Valid_in;
      stage_d.is_zero    = bus.Is_Zero_in;
      stage_d.alu_result = bus.ALU_Result_in;
      stage_d.write_data = bus.WriteData_in;
      stage_d.pc_branch  = bus.PC_Branch_in;
      stage_d.rd         = bus.RegisterRd_in;
      if (!bus.Valid_in) begin
        cnt_d = cnt_sat;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Valid_out      = stage_q.valid;
  assign bus.MemToReg_out   = stage_q.mem_to_reg;
  assign bus.RegWrite_out   = stage_q.reg_write;
  assign bus.MemWrite_out   = stage_q.mem_write;
  assign bus.MemRead_out    = stage_q.mem_read;
  assign bus.Branch_out     = stage_q.branch;
  assign bus.Is_Zero_out    = stage_q.is_zero;
  assign bus.ALU_Result_out = stage_q.alu_result;
  assign bus.WriteData_out  = stage_q.write_data;
  assign bus.PC_Branch_out  = stage_q.pc_branch;
  assign bus.RegisterRd_out = stage_q.rd;
  assign bus.Bubble_Count   = cnt_q;

endmodule
